pc_fetch: RTL and testbench

Fetch-stage front end of the pipelined MIPS core, directly upstream of the instruction memory. Holds the program counter and drives the instruction-memory fetch address. Selects the next PC from sequential, branch, jump and jump-register sources. Latches the returned instruction into the IF/ID pipeline register consumed by decode. Branch delay slots are architectural, so branches and jumps never flush.

---
 rtl/pc_fetch.sv | 86 ++++++++
 tb/tb_pc_fetch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// MIPS fetch stage: program counter, next-PC select and the IF/ID pipeline register.
// Optional exception vectoring (exc_req / epc_out) is enabled by defining EXC_VECTOR_EN.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_imm16,
  input  logic        j_en,
  input  logic [25:0] j_index,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  input  logic [31:0] im_instr,
`ifdef EXC_VECTOR_EN
  input  logic        exc_req,
  output logic [31:0] epc_out,
`endif
  output logic [31:0] pc_if,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic [31:0] pc8_id,
  output logic        fault_id
);

  localparam int unsigned PC_W   = 32;
  localparam int unsigned END_W  = PC_W + 1;
  // One bit wider so a window ending exactly at 2^32 does not wrap.
  localparam logic [END_W-1:0] IM_END = END_W'(RESET_PC) + (END_W'(IM_WORDS) << 2);
`ifdef EXC_VECTOR_EN
  localparam logic [PC_W-1:0] EXC_PC = 32'h0000_4180;
`endif

  logic [PC_W-1:0] npc_c;
  logic [PC_W-1:0] br_target_c;
  logic            fault_c;

  // Next-PC select: jr > j > taken branch > sequential.
  always_comb begin
    br_target_c = pc_id + PC_W'(4) + {{14{br_imm16[15]}}, br_imm16, 2'b00};
    npc_c       = pc_if + PC_W'(4);
    if (jr_en) begin
      npc_c = jr_target;
    end else if (j_en) begin
      npc_c = {pc_id[31:28], j_index, 2'b00};
    end else if (br_taken) begin
      npc_c = br_target_c;
    end
  end

  // Fetch is illegal when misaligned or outside the instruction memory window.
  always_comb begin
    fault_c = (pc_if[1:0] != 2'b00)
           || (pc_if < RESET_PC)
           || ({1'b0, pc_if} >= IM_END);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_if    <= RESET_PC;
      instr_id <= '0;
      pc_id    <= RESET_PC;
      pc8_id   <= RESET_PC + PC_W'(8);
      fault_id <= 1'b0;
`ifdef EXC_VECTOR_EN
      epc_out  <= '0;
    end else if (exc_req) begin
      pc_if    <= EXC_PC;
      instr_id <= '0;
      pc_id    <= EXC_PC;
      pc8_id   <= EXC_PC + PC_W'(8);
      fault_id <= 1'b0;
      epc_out  <= pc_id;
`endif
    end else if (!stall) begin
      pc_if    <= npc_c;
      instr_id <= fault_c ? '0 : im_instr;
      pc_id    <= pc_if;
      pc8_id   <= pc_if + PC_W'(8);
      fault_id <= fault_c;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: spec-level reference model checked every cycle, plus directed literal checks.
module tb_pc_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [32:0] IM_END   = 33'h0_0000_7000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_taken, j_en, jr_en, const_mode;
  logic [15:0] br_imm16;
  logic [25:0] j_index;
  logic [31:0] jr_target, im_instr;
  logic [31:0] pc_if, instr_id, pc_id, pc8_id;
  logic        fault_id;
`ifdef EXC_VECTOR_EN
  logic [31:0] epc_out;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instruction memory: constant word, or a word tagged with its own address.
  assign im_instr = const_mode ? 32'h2408_0001 : {16'h2408, pc_if[15:0]};

  pc_fetch dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_taken(br_taken), .br_imm16(br_imm16),
    .j_en(j_en), .j_index(j_index),
    .jr_en(jr_en), .jr_target(jr_target),
    .im_instr(im_instr),
`ifdef EXC_VECTOR_EN
    .exc_req(1'b0), .epc_out(epc_out),
`endif
    .pc_if(pc_if), .instr_id(instr_id), .pc_id(pc_id),
    .pc8_id(pc8_id), .fault_id(fault_id)
  );

  // Reference model: architectural PC and the instruction/PC handed to decode.
  logic [31:0] m_pc, m_instr, m_pcid;
  logic        m_fault;

  function automatic logic legal(input logic [31:0] a);
    return a[1:0] == 2'b00 && a >= RESET_PC && {1'b0, a} < IM_END;
  endfunction

  function automatic logic [31:0] target(input logic [31:0] pc, input logic [31:0] pcid);
    int signed off;
    off = int'(signed'(br_imm16)) * 4;
    if (jr_en)    return jr_target;
    if (j_en)     return {pcid[31:28], j_index, 2'b00};
    if (br_taken) return pcid + 32'd4 + 32'(off);
    return pc + 32'd4;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc    <= RESET_PC;
      m_instr <= 32'h0;
      m_pcid  <= RESET_PC;
      m_fault <= 1'b0;
    end else if (!stall) begin
      m_pc    <= target(m_pc, m_pcid);
      m_instr <= !legal(m_pc) ? 32'h0 : (const_mode ? 32'h2408_0001 : {16'h2408, m_pc[15:0]});
      m_pcid  <= m_pc;
      m_fault <= !legal(m_pc);
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model while out of reset.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      cmp("model.pc_if", pc_if, m_pc);
      cmp("model.instr_id", instr_id, m_instr);
      cmp("model.pc_id", pc_id, m_pcid);
      cmp("model.pc8_id", pc8_id, m_pcid + 32'd8);
      cmp("model.fault_id", 32'(fault_id), 32'(m_fault));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    cmp({tag, ".pc_if"}, pc_if, 32'h0000_3000);
    cmp({tag, ".instr_id"}, instr_id, 32'h0);
    cmp({tag, ".pc_id"}, pc_id, 32'h0000_3000);
    cmp({tag, ".pc8_id"}, pc8_id, 32'h0000_3008);
    cmp({tag, ".fault_id"}, 32'(fault_id), 32'h0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; br_taken = 1'b0; j_en = 1'b0; jr_en = 1'b0;
    br_imm16 = 16'h0; j_index = 26'h0; jr_target = 32'h0; const_mode = 1'b1;
    repeat (2) step();
    chk_reset("rst");
    reset = 1'b1;

    // Free-running sequential fetch.
    step();
    cmp("seq1.pc_if", pc_if, 32'h0000_3004);
    cmp("seq1.pc_id", pc_id, 32'h0000_3000);
    cmp("seq1.instr_id", instr_id, 32'h2408_0001);
    step();
    cmp("seq2.pc_if", pc_if, 32'h0000_3008);
    cmp("seq2.pc8_id", pc8_id, 32'h0000_300C);

    // Two-cycle stall holds everything.
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      cmp("stall.pc_if", pc_if, 32'h0000_3008);
      cmp("stall.pc_id", pc_id, 32'h0000_3004);
      cmp("stall.instr_id", instr_id, 32'h2408_0001);
    end
    stall = 1'b0;
    step();
    cmp("resume.pc_if", pc_if, 32'h0000_300C);
    const_mode = 1'b0;
    step();
    cmp("tagged.instr_id", instr_id, 32'h2408_300C);
    step();
    cmp("pre_br.pc_id", pc_id, 32'h0000_3010);

    // Backward branch; delay slot 3014 still latched.
    br_taken = 1'b1; br_imm16 = 16'hFFFC;
    step();
    br_taken = 1'b0;
    cmp("br.pc_if", pc_if, 32'h0000_3004);
    cmp("br.delay_slot", instr_id, 32'h2408_3014);
    repeat (8) step();
    cmp("pre_j.pc_id", pc_id, 32'h0000_3020);

    // Jump, then jump + jr together (jr wins).
    j_en = 1'b1; j_index = 26'h000_0C10;
    step();
    cmp("j.pc_if", pc_if, 32'h0000_3040);
    jr_en = 1'b1; jr_target = 32'h0000_3100;
    step();
    cmp("jr_prio.pc_if", pc_if, 32'h0000_3100);
    j_en = 1'b0;

    // Misaligned and out-of-window fetches.
    jr_target = 32'h0000_3002;
    step();
    jr_en = 1'b0;
    step();
    cmp("mis.pc_if", pc_if, 32'h0000_3006);
    cmp("mis.fault_id", 32'(fault_id), 32'h1);
    cmp("mis.instr_id", instr_id, 32'h0);
    jr_en = 1'b1; jr_target = 32'h0000_7000;
    step();
    jr_en = 1'b0;
    step();
    cmp("oow.pc_if", pc_if, 32'h0000_7004);
    cmp("oow.fault_id", 32'(fault_id), 32'h1);
    cmp("oow.instr_id", instr_id, 32'h0);

    // Last legal word does not fault.
    jr_en = 1'b1; jr_target = 32'h0000_6FFC;
    step();
    jr_en = 1'b0;
    step();
    cmp("last.fault_id", 32'(fault_id), 32'h0);
    cmp("last.instr_id", instr_id, 32'h2408_6FFC);

    // Redirect presented during a stall is held until the stall drops.
    stall = 1'b1; br_taken = 1'b1; br_imm16 = 16'h0010;
    step();
    cmp("stall_br.pc_if", pc_if, 32'h0000_7000);
    stall = 1'b0;
    step();
    br_taken = 1'b0;
    cmp("post_stall_br.pc_if", pc_if, 32'h0000_7040);

    // Asynchronous reset mid-cycle at pc_if=3040.
    jr_en = 1'b1; jr_target = 32'h0000_3040;
    step();
    jr_en = 1'b0;
    cmp("pre_rst.pc_if", pc_if, 32'h0000_3040);
    #2 reset = 1'b0;
    #1 chk_reset("async_rst");
    step();
    reset = 1'b1;
    step();
    cmp("rerun.pc_if", pc_if, 32'h0000_3004);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
